yarp_decode_stage: RTL and testbench



---
 rtl/yarp_pkg.sv | 40 ++++
 rtl/yarp_decode_comb.sv | 54 +++++
 rtl/yarp_decode_stage.sv | 100 ++++++++++
 tb/tb_yarp_decode_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp decode stage: RV32/RV64 opcode map and the decoded-instruction record.
// YARP_DECODE_ILLEGAL_EN adds an illegal-instruction flag to the record.
package yarp_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [6:0] {
        R_TYPE       = 7'h33,
        I_TYPE_LOAD  = 7'h03,
        I_TYPE_ALU   = 7'h13,
        I_TYPE_JALR  = 7'h67,
        S_TYPE       = 7'h23,
        B_TYPE       = 7'h63,
        U_TYPE_LUI   = 7'h37,
        U_TYPE_AUIPC = 7'h17,
        J_TYPE       = 7'h6F
    } opcode_e;

    // imm and pc are sized for the widest XLEN; narrower stages use the low bits
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        logic [6:0]          op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                r_type;
        logic                i_type;
        logic                s_type;
        logic                b_type;
        logic                u_type;
        logic                j_type;
`ifdef YARP_DECODE_ILLEGAL_EN
        logic                illegal;
`endif
    } decode_t;

endpackage

// File: rtl/yarp_decode_comb.sv
// Pure combinational RISC-V field/type/immediate decode of one instruction.
// With YARP_DECODE_ILLEGAL_EN the illegal flag is also computed.
import yarp_pkg::*;

module yarp_decode_comb #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decode_t         dec
);

    always_comb begin
        dec = '0;
        dec.pc[XLEN-1:0] = pc;
        dec.op     = instr[6:0];
        dec.rd     = instr[11:7];
        dec.funct3 = instr[14:12];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct7 = instr[31:25];
        // immediates are built at 64 bits; truncation keeps them sign-extended at any XLEN
        case (opcode_e'(instr[6:0]))
            R_TYPE: dec.r_type = 1'b1;
            I_TYPE_LOAD, I_TYPE_ALU, I_TYPE_JALR: begin
                dec.i_type = 1'b1;
                dec.imm    = {{52{instr[31]}}, instr[31:20]};
            end
            S_TYPE: begin
                dec.s_type = 1'b1;
                dec.imm    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            end
            B_TYPE: begin
                dec.b_type = 1'b1;
                dec.imm    = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            U_TYPE_LUI, U_TYPE_AUIPC: begin
                dec.u_type = 1'b1;
                dec.imm    = {{32{instr[31]}}, instr[31:12], 12'b0};
            end
            J_TYPE: begin
                dec.j_type = 1'b1;
                dec.imm    = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
`ifdef YARP_DECODE_ILLEGAL_EN
        dec.illegal = !(dec.r_type | dec.i_type | dec.s_type | dec.b_type | dec.u_type | dec.j_type)
                    || (dec.r_type && instr[31:25] != 7'h00 && instr[31:25] != 7'h20)
                    || (instr[6:0] == I_TYPE_JALR && instr[14:12] != 3'b000);
`endif
    end

endmodule

// File: rtl/yarp_decode_stage.sv
// Registered decode stage with valid/ready handshake and a one-entry skid register.
// Optional YARP_DECODE_ILLEGAL_EN adds the illegal_o output.
import yarp_pkg::*;

module yarp_decode_stage #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] PC_RST = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            r_type_instr_o,
    output logic            i_type_instr_o,
    output logic            s_type_instr_o,
    output logic            b_type_instr_o,
    output logic            u_type_instr_o,
    output logic            j_type_instr_o,
`ifdef YARP_DECODE_ILLEGAL_EN
    output logic            illegal_o,
`endif
    output logic [XLEN-1:0] instr_imm_o
);

    decode_t dec;
    decode_t out_q;
    decode_t skid_q;
    logic    out_vld;
    logic    skid_vld;
    logic    accept;
    logic    out_load;

    yarp_decode_comb #(.XLEN(XLEN)) u_comb (
        .instr (instr_i),
        .pc    (pc_i),
        .dec   (dec)
    );

    // ready depends only on registered skid state, never on ready_i
    assign ready_o  = !skid_vld;
    assign accept   = valid_i && ready_o;
    assign out_load = !out_vld || ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_load) begin
            if (skid_vld) begin
                // skid full blocks new input, so only the skid entry moves
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= accept;
                if (accept) out_q <= dec;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign valid_o        = out_vld;
    assign pc_o           = out_vld ? out_q.pc[XLEN-1:0] : PC_RST;
    assign rs1_o          = out_q.rs1;
    assign rs2_o          = out_q.rs2;
    assign rd_o           = out_q.rd;
    assign op_o           = out_q.op;
    assign funct3_o       = out_q.funct3;
    assign funct7_o       = out_q.funct7;
    assign r_type_instr_o = out_q.r_type;
    assign i_type_instr_o = out_q.i_type;
    assign s_type_instr_o = out_q.s_type;
    assign b_type_instr_o = out_q.b_type;
    assign u_type_instr_o = out_q.u_type;
    assign j_type_instr_o = out_q.j_type;
    assign instr_imm_o    = out_q.imm[XLEN-1:0];
`ifdef YARP_DECODE_ILLEGAL_EN
    assign illegal_o      = out_q.illegal;
`endif

endmodule

// File: tb/tb_yarp_decode_stage.sv
// Randomized + directed bench for yarp_decode_stage; runs an XLEN=32 and an XLEN=64 instance in lockstep.
module tb_yarp_decode_stage;

    localparam logic [31:0] RST32 = 32'h0000_1000;
    localparam logic [63:0] RST64 = 64'hFFFF_0000_0000_2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [63:0] pc_in = '0;

    logic        rdy32, v32, rdy64, v64;
    logic [31:0] pc32, imm32;
    logic [63:0] pc64, imm64;
    logic [4:0]  rs1_32, rs2_32, rd_32, rs1_64, rs2_64, rd_64;
    logic [6:0]  op32, f7_32, op64, f7_64;
    logic [2:0]  f3_32, f3_64;
    logic        r32, i32, s32, b32, u32, j32;
    logic        r64, i64, s64, b64, u64, j64;
    logic        ill32, ill64;

    yarp_decode_stage #(.XLEN(32), .PC_RST(RST32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy32),
        .instr_i(instr_i), .pc_i(pc_in[31:0]), .valid_o(v32), .ready_i(ready_i), .pc_o(pc32),
        .rs1_o(rs1_32), .rs2_o(rs2_32), .rd_o(rd_32), .op_o(op32), .funct3_o(f3_32), .funct7_o(f7_32),
        .r_type_instr_o(r32), .i_type_instr_o(i32), .s_type_instr_o(s32), .b_type_instr_o(b32),
        .u_type_instr_o(u32), .j_type_instr_o(j32),
`ifdef YARP_DECODE_ILLEGAL_EN
        .illegal_o(ill32),
`endif
        .instr_imm_o(imm32)
    );

    yarp_decode_stage #(.XLEN(64), .PC_RST(RST64)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy64),
        .instr_i(instr_i), .pc_i(pc_in), .valid_o(v64), .ready_i(ready_i), .pc_o(pc64),
        .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd_64), .op_o(op64), .funct3_o(f3_64), .funct7_o(f7_64),
        .r_type_instr_o(r64), .i_type_instr_o(i64), .s_type_instr_o(s64), .b_type_instr_o(b64),
        .u_type_instr_o(u64), .j_type_instr_o(j64),
`ifdef YARP_DECODE_ILLEGAL_EN
        .illegal_o(ill64),
`endif
        .instr_imm_o(imm64)
    );

`ifndef YARP_DECODE_ILLEGAL_EN
    assign ill32 = 1'b0;
    assign ill64 = 1'b0;
`endif

    always #5 clk = ~clk;

    wire [5:0] t32 = {r32, i32, s32, b32, u32, j32};
    wire [5:0] t64 = {r64, i64, s64, b64, u64, j64};

    typedef struct { logic [31:0] instr; logic [63:0] pc; } txn_t;
    txn_t q[$];
    int checks = 0;
    int failures = 0;

    // reference: type as {r,i,s,b,u,j}
    function automatic logic [5:0] m_type(logic [31:0] in);
        case (in[6:0])
            7'h33:               return 6'b100000;
            7'h03, 7'h13, 7'h67: return 6'b010000;
            7'h23:               return 6'b001000;
            7'h63:               return 6'b000100;
            7'h37, 7'h17:        return 6'b000010;
            7'h6F:               return 6'b000001;
            default:             return 6'b000000;
        endcase
    endfunction

    function automatic longint m_imm(logic [31:0] in);
        longint s;
        s = longint'($signed(in));
        case (m_type(in))
            6'b010000: return s >>> 20;
            6'b001000: return (s >>> 25) * 32 + longint'(in[11:7]);
            6'b000100: return (in[31] ? -64'sd4096 : 64'sd0) + longint'(in[7]) * 2048
                              + longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2;
            6'b000010: return longint'($signed(in & 32'hFFFFF000));
            6'b000001: return (in[31] ? -64'sd1048576 : 64'sd0) + longint'(in[19:12]) * 4096
                              + longint'(in[20]) * 2048 + longint'(in[30:21]) * 2;
            default:   return 0;
        endcase
    endfunction

    function automatic logic m_illegal(logic [31:0] in);
        return (m_type(in) == 6'b0)
            || (in[6:0] == 7'h33 && in[31:25] != 7'h00 && in[31:25] != 7'h20)
            || (in[6:0] == 7'h67 && in[14:12] != 3'b000);
    endfunction

    // advance one clock, updating the model queue (capacity two, in order)
    task automatic cycle();
        logic acc, drn;
        txn_t t;
        acc = valid_i && (q.size() < 2);
        drn = ready_i && (q.size() > 0);
        t.instr = instr_i;
        t.pc = pc_in;
        @(posedge clk);
        if (flush_i) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(t);
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] in, input logic [63:0] pc);
        instr_i = in; pc_in = pc; valid_i = 1'b1; ready_i = 1'b1;
        cycle();
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (v32 !== 1'b0 || v64 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b/%b exp=0", v32, v64); end
        checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b/%b exp=1", rdy32, rdy64); end
        checks++; if (pc32 !== RST32 || pc64 !== RST64) begin failures++; $display("FAIL reset_pc got=%h/%h exp=%h/%h", pc32, pc64, RST32, RST64); end
        checks++; if (imm32 !== 32'h0 || t32 !== 6'b0 || rd_32 !== 5'h0 || op32 !== 7'h0 || ill32 !== 1'b0) begin
            failures++; $display("FAIL reset_payload got imm=%h type=%b rd=%h op=%h ill=%b exp=0", imm32, t32, rd_32, op32, ill32); end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_decode();
        issue(32'hFFF10093, 64'h100);
        checks++; if (v32 !== 1'b1 || t32 !== 6'b010000 || rd_32 !== 5'd1 || rs1_32 !== 5'd2) begin
            failures++; $display("FAIL addi_fields got v=%b type=%b rd=%0d rs1=%0d exp v=1 type=010000 rd=1 rs1=2", v32, t32, rd_32, rs1_32); end
        checks++; if (imm32 !== 32'hFFFFFFFF || imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
            failures++; $display("FAIL addi_imm got=%h/%h exp=ffffffff/ffffffffffffffff", imm32, imm64); end
        checks++; if (pc32 !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=00000100", pc32); end
        issue(32'h008000EF, 64'h104);
        checks++; if (t32 !== 6'b000001 || imm32 !== 32'h8) begin
            failures++; $display("FAIL jal got type=%b imm=%h exp type=000001 imm=00000008", t32, imm32); end
        issue(32'h123452B7, 64'h108);
        checks++; if (t32 !== 6'b000010 || imm32 !== 32'h12345000 || rd_32 !== 5'd5) begin
            failures++; $display("FAIL lui got type=%b imm=%h rd=%0d exp type=000010 imm=12345000 rd=5", t32, imm32, rd_32); end
        issue(32'h800002B7, 64'h10C);
        checks++; if (imm64 !== 64'hFFFFFFFF80000000 || t64 !== 6'b000010) begin
            failures++; $display("FAIL lui64 got imm=%h type=%b exp imm=ffffffff80000000 type=000010", imm64, t64); end
        checks++; if (imm32 !== 32'h80000000) begin failures++; $display("FAIL lui32 got=%h exp=80000000", imm32); end
        cycle();
        checks++; if (v32 !== 1'b0) begin failures++; $display("FAIL decode_drain got=%b exp=0", v32); end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h00100093; pc_in = 64'hA0; cycle();
        checks++; if (v32 !== 1'b1 || rdy32 !== 1'b1 || pc32 !== 32'hA0) begin
            failures++; $display("FAIL b2b_a got v=%b rdy=%b pc=%h exp v=1 rdy=1 pc=a0", v32, rdy32, pc32); end
        instr_i = 32'h00200093; pc_in = 64'hB0; cycle();
        checks++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || pc32 !== 32'hA0) begin
            failures++; $display("FAIL b2b_skid got rdy=%b/%b pc=%h exp rdy=0 pc=a0", rdy32, rdy64, pc32); end
        instr_i = 32'h00300093; pc_in = 64'hC0; cycle();
        checks++; if (v32 !== 1'b1 || rdy32 !== 1'b0 || pc32 !== 32'hA0 || imm32 !== 32'h1) begin
            failures++; $display("FAIL b2b_hold got v=%b rdy=%b pc=%h imm=%h exp v=1 rdy=0 pc=a0 imm=1", v32, rdy32, pc32, imm32); end
        ready_i = 1'b1; cycle();
        checks++; if (v32 !== 1'b1 || pc32 !== 32'hB0 || imm32 !== 32'h2 || rdy32 !== 1'b1) begin
            failures++; $display("FAIL b2b_b got v=%b pc=%h imm=%h rdy=%b exp v=1 pc=b0 imm=2 rdy=1", v32, pc32, imm32, rdy32); end
        cycle();
        checks++; if (v32 !== 1'b1 || pc32 !== 32'hC0 || imm32 !== 32'h3) begin
            failures++; $display("FAIL b2b_c got v=%b pc=%h imm=%h exp v=1 pc=c0 imm=3", v32, pc32, imm32); end
        valid_i = 1'b0; cycle();
        checks++; if (v32 !== 1'b0 || pc32 !== RST32) begin
            failures++; $display("FAIL b2b_empty got v=%b pc=%h exp v=0 pc=%h", v32, pc32, RST32); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h00000013; pc_in = 64'h200; cycle();
        pc_in = 64'h204; cycle();
        checks++; if (rdy32 !== 1'b0 || v32 !== 1'b1) begin failures++; $display("FAIL flush_fill got rdy=%b v=%b exp rdy=0 v=1", rdy32, v32); end
        flush_i = 1'b1; pc_in = 64'h208; cycle();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (v32 !== 1'b0 || v64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1 || pc32 !== RST32) begin
            failures++; $display("FAIL flush got v=%b/%b rdy=%b/%b pc=%h exp v=0 rdy=1 pc=%h", v32, v64, rdy32, rdy64, pc32, RST32); end
        ready_i = 1'b1; cycle();
        checks++; if (v32 !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b exp=0", v32); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h123452B7; pc_in = 64'h300; cycle();
        pc_in = 64'h304; cycle();
        valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        q.delete();
        checks++; if (v32 !== 1'b0 || v64 !== 1'b0 || rdy32 !== 1'b1 || pc32 !== RST32 || pc64 !== RST64) begin
            failures++; $display("FAIL async_reset got v=%b/%b rdy=%b pc=%h/%h exp v=0 rdy=1 pc=%h/%h", v32, v64, rdy32, pc32, pc64, RST32, RST64); end
        checks++; if (imm32 !== 32'h0 || t32 !== 6'b0 || rd_32 !== 5'h0) begin
            failures++; $display("FAIL async_reset_payload got imm=%h type=%b rd=%h exp 0", imm32, t32, rd_32); end
        #2 reset_n = 1'b1;
        ready_i = 1'b1;
        cycle();
    endtask

`ifdef YARP_DECODE_ILLEGAL_EN
    task automatic test_illegal();
        issue(32'hFFFFF07F, 64'h400);
        checks++; if (ill32 !== 1'b1 || t32 !== 6'b0 || imm32 !== 32'h0 || imm64 !== 64'h0) begin
            failures++; $display("FAIL ill_opcode got ill=%b type=%b imm=%h exp ill=1 type=0 imm=0", ill32, t32, imm32); end
        issue(32'h02000033, 64'h404);
        checks++; if (ill32 !== 1'b1 || t32 !== 6'b100000) begin
            failures++; $display("FAIL ill_funct7 got ill=%b type=%b exp ill=1 type=100000", ill32, t32); end
        issue(32'h00001067, 64'h408);
        checks++; if (ill64 !== 1'b1) begin failures++; $display("FAIL ill_jalr got=%b exp=1", ill64); end
        issue(32'h40000033, 64'h40C);
        checks++; if (ill32 !== 1'b0) begin failures++; $display("FAIL ill_sub got=%b exp=0", ill32); end
        cycle();
    endtask
`endif

    task automatic test_random();
        logic [6:0]  ops [10] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        logic [31:0] r;
        logic [6:0]  op;
        logic [63:0] eimm;
        for (int n = 0; n < 600; n++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h00) op = 7'($urandom());
            instr_i = {r[31:7], op};
            pc_in   = {$urandom(), $urandom()};
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 40) == 0);
            cycle();
            checks++; if (v32 !== (q.size() > 0) || v64 !== (q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", n, v32, v64, q.size() > 0); end
            checks++; if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2)) begin
                failures++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", n, rdy32, rdy64, q.size() < 2); end
            if (q.size() > 0) begin
                eimm = 64'(m_imm(q[0].instr));
                checks++; if (pc32 !== q[0].pc[31:0] || pc64 !== q[0].pc) begin
                    failures++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", n, pc32, pc64, q[0].pc); end
                checks++; if (imm32 !== eimm[31:0] || imm64 !== eimm) begin
                    failures++; $display("FAIL rnd_imm cyc=%0d instr=%h got=%h/%h exp=%h", n, q[0].instr, imm32, imm64, eimm); end
                checks++; if (t32 !== m_type(q[0].instr) || t64 !== m_type(q[0].instr)) begin
                    failures++; $display("FAIL rnd_type cyc=%0d got=%b/%b exp=%b", n, t32, t64, m_type(q[0].instr)); end
                checks++; if ({rd_32, rs1_32, rs2_32, op32, f3_32, f7_32} !== {q[0].instr[11:7], q[0].instr[19:15],
                        q[0].instr[24:20], q[0].instr[6:0], q[0].instr[14:12], q[0].instr[31:25]}
                        || {rd_64, rs1_64, rs2_64, op64, f3_64, f7_64} !== {rd_32, rs1_32, rs2_32, op32, f3_32, f7_32}) begin
                    failures++; $display("FAIL rnd_fields cyc=%0d instr=%h got rd=%h rs1=%h rs2=%h op=%h f3=%h f7=%h",
                        n, q[0].instr, rd_32, rs1_32, rs2_32, op32, f3_32, f7_32); end
`ifdef YARP_DECODE_ILLEGAL_EN
                checks++; if (ill32 !== m_illegal(q[0].instr) || ill64 !== m_illegal(q[0].instr)) begin
                    failures++; $display("FAIL rnd_illegal cyc=%0d got=%b/%b exp=%b", n, ill32, ill64, m_illegal(q[0].instr)); end
`endif
            end else begin
                checks++; if (pc32 !== RST32 || pc64 !== RST64) begin
                    failures++; $display("FAIL rnd_idle_pc cyc=%0d got=%h/%h exp=%h/%h", n, pc32, pc64, RST32, RST64); end
            end
        end
        flush_i = 1'b0; valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef YARP_DECODE_ILLEGAL_EN
        test_illegal();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
